// File: rtl/gate_sweep_checker.sv
// Sweeps all four (a,b) vectors into a two-input gate block and checks the
// and/or/xor/nand responses against the truth table, reporting the first failure.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             in_a,
  output logic             in_b,
  input  logic             gate_and,
  input  logic             gate_or,
  input  logic             gate_xor,
  input  logic             gate_nand,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic [3:0]       fail_bits,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);

  state_t           state, state_n;
  logic [1:0]       vec, vec_n;
  logic [7:0]       pass_cnt, pass_cnt_n;
  logic [7:0]       settle_cnt, settle_cnt_n;
  logic [ERR_W-1:0] err_n;
  logic [1:0]       fail_vec_n;
  logic [3:0]       fail_bits_n;
  logic [3:0]       expected;
  logic [3:0]       mism;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_bits  <= '0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      pass_cnt   <= pass_cnt_n;
      settle_cnt <= settle_cnt_n;
      err_count  <= err_n;
      fail_vec   <= fail_vec_n;
      fail_bits  <= fail_bits_n;
    end
  end

  always_comb begin
    expected     = {~(vec[1] & vec[0]), vec[1] ^ vec[0], vec[1] | vec[0], vec[1] & vec[0]};
    mism         = {gate_nand, gate_xor, gate_or, gate_and} ^ expected;
    state_n      = state;
    vec_n        = vec;
    pass_cnt_n   = pass_cnt;
    settle_cnt_n = settle_cnt;
    err_n        = err_count;
    fail_vec_n   = fail_vec;
    fail_bits_n  = fail_bits;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = SETTLE;
          vec_n        = 2'b00;
          pass_cnt_n   = '0;
          settle_cnt_n = SETTLE_LOAD;
          err_n        = '0;
          fail_vec_n   = '0;
          fail_bits_n  = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt == 8'd0) state_n = CHECK;
        else settle_cnt_n = settle_cnt - 8'd1;
      end
      CHECK: begin
        if (mism != 4'b0000) begin
          if (err_count != {ERR_W{1'b1}}) err_n = err_count + ERR_W'(1);
          // err_count never returns to zero once set, so zero marks "no failure yet"
          if (err_count == '0) begin
            fail_vec_n  = vec;
            fail_bits_n = mism;
          end
        end
        if (vec == 2'b11 && pass_cnt == LAST_PASS) begin
          state_n = DONE;
        end else begin
          vec_n        = vec + 2'd1;
          if (vec == 2'b11) pass_cnt_n = pass_cnt + 8'd1;
          settle_cnt_n = SETTLE_LOAD;
          state_n      = SETTLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_a      = vec[1];
  assign in_b      = vec[0];
  assign busy      = (state == SETTLE) || (state == CHECK);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a fault-injectable gate model on each instance,
// a table of fault modes with expected reports, and hand-written corner sequences.
module tb_gate_sweep_checker;

  localparam int S = 2;

  logic       clk = 0;
  logic       rst;
  logic       start, start2;
  logic       in_a, in_b, in_a2, in_b2;
  logic [3:0] g, g2;
  logic       busy, done, pass, busy2, done2, pass2;
  logic [3:0] err_count;
  logic [1:0] err2;
  logic [1:0] fail_vec, fail_vec2, dbg, dbg2;
  logic [3:0] fail_bits, fail_bits2;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  // packed result {pass, err_count[3:0], fail_vec[1:0], fail_bits[3:0]}
  logic [10:0] exp_q[$];

  typedef struct {
    logic [1:0] mode;
    logic       exp_pass;
    logic [3:0] exp_err;
    logic [1:0] exp_fvec;
    logic [3:0] exp_fbits;
  } vec_t;
  vec_t tbl[3];

  always #5 clk = ~clk;

  // gate model: mode 0 golden, 1 and stuck at 0, 2 all outputs inverted
  always_comb begin
    g = {~(in_a & in_b), in_a ^ in_b, in_a | in_b, in_a & in_b};
    if (mode == 2'd1) g[0] = 1'b0;
    if (mode == 2'd2) g = ~g;
    g2 = ~{~(in_a2 & in_b2), in_a2 ^ in_b2, in_a2 | in_b2, in_a2 & in_b2};
  end

  gate_sweep_checker dut (
    .clk(clk), .rst(rst), .start(start), .in_a(in_a), .in_b(in_b),
    .gate_and(g[0]), .gate_or(g[1]), .gate_xor(g[2]), .gate_nand(g[3]),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_vec(fail_vec), .fail_bits(fail_bits), .dbg_state(dbg)
  );

  gate_sweep_checker #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_a(in_a2), .in_b(in_b2),
    .gate_and(g2[0]), .gate_or(g2[1]), .gate_xor(g2[2]), .gate_nand(g2[3]),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_vec(fail_vec2), .fail_bits(fail_bits2), .dbg_state(dbg2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_result();
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("result", {21'd0, pass, err_count, fail_vec, fail_bits}, {21'd0, e});
    end
  endtask

  // pulse start, follow the vector sequence and return edges until done
  task automatic run_sweep(input int extra, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("accept_state", {28'd0, busy, done, err_count == 4'd0, {in_a, in_b} == 2'b00}, 32'b1011);
    lat = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == extra);
      if (done) begin
        lat = cyc;
        break;
      end
      chk("seq", {29'd0, busy, in_a, in_b}, {29'd0, 1'b1, 2'(cyc / (S + 1))});
    end
    start = 1'b0;
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    else chk("hold_11", {30'd0, in_a, in_b}, 32'd3);
  endtask

  initial begin
    int lat;
    bit found;
    tbl[0] = '{2'd0, 1'b1, 4'd0, 2'b00, 4'b0000};
    tbl[1] = '{2'd1, 1'b0, 4'd1, 2'b11, 4'b0001};
    tbl[2] = '{2'd2, 1'b0, 4'd4, 2'b00, 4'b1111};
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {17'd0, in_a, in_b, busy, done, pass, err_count, fail_vec, fail_bits}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // table sweeps; entries after the first restart from DONE
    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      exp_q.push_back({tbl[i].exp_pass, tbl[i].exp_err, tbl[i].exp_fvec, tbl[i].exp_fbits});
      run_sweep(-1, lat);
      chk("latency", lat, 32'd12);
      check_result();
    end

    // start pulsed mid-sweep is ignored
    mode = 2'd0;
    exp_q.push_back({tbl[0].exp_pass, tbl[0].exp_err, tbl[0].exp_fvec, tbl[0].exp_fbits});
    run_sweep(5, lat);
    chk("latency_ignore", lat, 32'd12);
    check_result();

    // async reset during SETTLE of vector 10
    mode = 2'd2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if ({in_a, in_b} == 2'b10) begin
        found = 1;
        break;
      end
    end
    chk("reach_vec10", {31'd0, found}, 32'd1);
    chk("mid_state", {30'd0, dbg}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {15'd0, dbg, in_a, in_b, busy, done, pass, err_count, fail_vec, fail_bits}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mode = 2'd0;
    exp_q.push_back({tbl[0].exp_pass, tbl[0].exp_err, tbl[0].exp_fvec, tbl[0].exp_fbits});
    run_sweep(-1, lat);
    chk("latency_after_rst", lat, 32'd12);
    check_result();

    // two passes, narrow saturating counter, inverted gate
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        lat = cyc;
        break;
      end
    end
    chk("latency_2pass", lat, 32'd24);
    chk("sat_result", {24'd0, pass2, err2, fail_vec2, fail_bits2}, {24'd0, 1'b0, 2'd3, 2'b00, 4'b1111});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Self-checking stimulus/response stage that wraps the two-input logic gate block. It drives every (in_a, in_b) combination into the gate and consumes the gate's and/or/xor/nand outputs. Each result is compared against the expected truth table, and the block reports pass/fail, an error count and the first failing vector. It sits directly on both sides of the gate, so gate checking can be reused in-system or as a bench component.

Parameters:
SETTLE_CYCLES, 2, cycles to hold each vector before sampling gate outputs; legal range 1..255.
PASSES, 1, number of full 4-vector sweeps per start; legal range 1..255.
ERR_W, 4, width of the error counter; legal value >= 1.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a sweep.
in_a  output  1  vector bit A driven to gate; registered.
in_b  output  1  vector bit B driven to gate; registered.
gate_and  input  1  gate and output.
gate_or  input  1  gate or output.
gate_xor  input  1  gate xor output.
gate_nand  input  1  gate nand output.
busy  output  1  high while a sweep is in progress.
done  output  1  high after a sweep completes; held until the next accepted start or reset.
pass  output  1  equals done AND (err_count == 0).
err_count  output  ERR_W  count of mismatching checks; saturates at all-ones.
fail_vec  output  2  {a,b} of the first mismatching check.
fail_bits  output  4  mismatch mask at the first failing check; bit0 and, bit1 or, bit2 xor, bit3 nand.

Behaviour:
- Reset values (async, immediate): state IDLE; in_a=0, in_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_bits=0; internal vector, pass and settle counters are 0.
- The FSM has four states: IDLE, SETTLE, CHECK, DONE. busy=1 in SETTLE and CHECK. done=1 only in DONE.
- Vector order is 00, 01, 10, 11, with {in_a,in_b} = vector index (in_a is the MSB).
- IDLE or DONE with start=1:
  - go to SETTLE.
  - drive vector 00.
  - clear err_count, fail_vec, fail_bits and the pass counter.
  - load the settle counter with SETTLE_CYCLES-1.
  - done drops on the same edge.
- SETTLE: if the settle counter is 0, go to CHECK; otherwise decrement it. in_a and in_b are held stable.
- CHECK (single cycle): the comparison is evaluated on the exiting edge.
  - Expected values: and = a&b, or = a|b, xor = a^b, nand = ~(a&b).
  - mism = 4-bit XOR of actual vs expected.
  - If mism != 0: err_count increments, saturating at 2^ERR_W-1. If this is the first mismatch since start, capture fail_vec and fail_bits.
  - If this is vector 11 of pass PASSES-1: go to DONE; in_a and in_b hold 11.
  - Otherwise: advance the vector, wrapping 11 -> 00 and incrementing the pass counter on wrap; reload the settle counter; go to SETTLE.
- Latency:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises 4*PASSES*(SETTLE_CYCLES+1) edges after the edge that accepted start.
  - With the defaults, that is 12 edges.
- start while busy is ignored; the sweep is unaffected.
- start in DONE restarts a sweep, with the same behaviour as start in IDLE.
- rst mid-sweep aborts immediately to the reset values. No partial results are retained.
- Gate outputs are sampled only in CHECK. Glitches during SETTLE have no effect.

Test Plan:
- Golden gate connected, defaults, start pulse at cycle 0 -> busy for 12 cycles, done=1 at edge 12, pass=1, err_count=0, fail_vec=00, fail_bits=0000; in_a/in_b sequence 00,01,10,11, each held 3 cycles.
- gate_and stuck at 0 -> done at edge 12, err_count=1, pass=0, fail_vec=11, fail_bits=0001.
- All four gate outputs inverted -> err_count=4, fail_vec=00, fail_bits=1111, pass=0.
- ERR_W=2, PASSES=2, outputs inverted -> 8 mismatches, err_count saturates at 3, done at edge 24, fail_vec stays 00.
- rst asserted asynchronously during SETTLE of vector 10 -> all outputs return to 0 at once, without waiting for a clock edge. A start after release gives a full clean 12-cycle sweep.
- start pulsed again at cycle 5 during a sweep -> ignored, done still at edge 12. A start pulse while done=1 -> done clears next edge and a fresh sweep runs with err_count reset to 0.
